// File: rtl/sample_frame_pkg.sv
// sample_frame_pkg: shared FSM states and sizing helpers for the sample frame streamer.
package sample_frame_pkg;

    typedef enum logic [1:0] {IDLE, SYNC, DATA, CSUM} state_e;

    localparam logic [7:0] DEF_SYNC_BYTE = 8'hA5;

    function automatic int bytes_per_ch(input int data_w);
        return (data_w + 7) / 8;
    endfunction

endpackage

// File: rtl/frame_fifo_mem.sv
// frame_fifo_mem: simple dual-port frame storage, synchronous write, asynchronous read.
module frame_fifo_mem #(
    parameter int WIDTH = 48,
    parameter int DEPTH = 8,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we_i,
    input  logic [AW-1:0]    waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic [AW-1:0]    raddr_i,
    output logic [WIDTH-1:0] rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk)
        if (we_i) mem_q[waddr_i] <= wdata_i;

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/sample_frame_streamer.sv
// sample_frame_streamer: buffers multi-channel sample frames and streams each one
// as a SYNC / data bytes / XOR-checksum packet over a valid/ready byte port.
module sample_frame_streamer
    import sample_frame_pkg::*;
#(
    parameter int         N_CH      = 2,
    parameter int         DATA_W    = 24,
    parameter int         DEPTH     = 8,
    parameter int         OVF_MODE  = 0,
    parameter logic [7:0] SYNC_BYTE = DEF_SYNC_BYTE
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      in_valid,
    input  logic [N_CH*DATA_W-1:0]    in_data,
    input  logic                      stream_en,
    input  logic                      flush,
    output logic [7:0]                out_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic                      frame_active,
    output logic [$clog2(DEPTH):0]    level,
    output logic                      empty,
    output logic                      full,
    output logic [15:0]               drop_count
);

    localparam int AW  = $clog2(DEPTH);
    localparam int BPC = bytes_per_ch(DATA_W);
    localparam int NB  = N_CH * BPC;
    localparam int SW  = NB * 8;
    localparam int CW  = $clog2(NB + 1);

    state_e             state_q;
    logic [AW:0]        wr_ptr_q, rd_ptr_q, wr_ptr_d, rd_ptr_d;
    logic [15:0]        drop_q, drop_d;
    logic [SW-1:0]      shift_q, frame_bytes;
    logic [CW-1:0]      cnt_q;
    logic [7:0]         csum_q, out_data_q;
    logic               out_valid_q;
    logic [N_CH*DATA_W-1:0] rd_data;
    logic               pop, blocked, we, ovw;

    assign level        = wr_ptr_q - rd_ptr_q;
    assign empty        = level == '0;
    assign full         = level == (AW+1)'(DEPTH);
    assign pop          = state_q == IDLE && stream_en && !empty;
    assign blocked      = in_valid && !flush && full && !pop;
    assign ovw          = blocked && OVF_MODE == 1;
    assign we           = (in_valid && !flush && (!full || pop)) || ovw;
    assign wr_ptr_d     = flush ? '0 : wr_ptr_q + (AW+1)'(we);
    assign rd_ptr_d     = flush ? '0 : rd_ptr_q + (AW+1)'(pop || ovw);
    assign drop_d       = drop_q + 16'(blocked && drop_q != 16'hFFFF);
    assign out_data     = out_data_q;
    assign out_valid    = out_valid_q;
    assign frame_active = state_q != IDLE;

    frame_fifo_mem #(.WIDTH(N_CH*DATA_W), .DEPTH(DEPTH)) u_mem (
        .clk     (clk),
        .we_i    (we),
        .waddr_i (wr_ptr_q[AW-1:0]),
        .wdata_i (in_data),
        .raddr_i (rd_ptr_q[AW-1:0]),
        .rdata_o (rd_data)
    );

    // Channel 0 lands in the top bytes so a left shift emits ch0 MSB first.
    always_comb begin
        frame_bytes = '0;
        for (int c = 0; c < N_CH; c++)
            frame_bytes[SW-1-c*BPC*8 -: BPC*8] = (BPC*8)'(rd_data[c*DATA_W +: DATA_W]);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            drop_q      <= '0;
            shift_q     <= '0;
            cnt_q       <= '0;
            csum_q      <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            drop_q   <= drop_d;
            case (state_q)
                IDLE: if (pop) begin
                    shift_q     <= frame_bytes;
                    csum_q      <= '0;
                    cnt_q       <= '0;
                    out_data_q  <= SYNC_BYTE;
                    out_valid_q <= 1'b1;
                    state_q     <= SYNC;
                end
                SYNC: if (out_ready) begin
                    out_data_q <= shift_q[SW-1 -: 8];
                    shift_q    <= shift_q << 8;
                    state_q    <= DATA;
                end
                DATA: if (out_ready) begin
                    csum_q <= csum_q ^ out_data_q;
                    cnt_q  <= cnt_q + 1'b1;
                    if (cnt_q == CW'(NB - 1)) begin
                        out_data_q <= csum_q ^ out_data_q;
                        state_q    <= CSUM;
                    end else begin
                        out_data_q <= shift_q[SW-1 -: 8];
                        shift_q    <= shift_q << 8;
                    end
                end
                CSUM: if (out_ready) begin
                    out_data_q  <= '0;
                    out_valid_q <= 1'b0;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

    assign drop_count = drop_q;

endmodule

// File: doc/sample_frame_streamer.md
Name: sample_frame_streamer

Overview:
- Parametrised successor to the single-pair sample FIFO that sits between data_buffer and wifiv1.
- Captures N_CH channels of DATA_W-bit results, for example HR, SpO2 or raw LED1/LED2, into a DEPTH-frame buffer on each result strobe.
- Serialises each buffered frame as a checksummed byte packet over a valid/ready byte interface, ready for a UART or Wi-Fi transmitter.
- Adds a selectable overflow policy, drop accounting, flush and stream gating.

Parameters:
- N_CH, 2, number of channels per frame (1..8).
- DATA_W, 24, bits per channel sample (1..32).
- DEPTH, 8, frames of storage; must be a power of 2, at least 2.
- OVF_MODE, 0, overflow policy: 0 = drop newest frame, 1 = overwrite oldest frame.
- SYNC_BYTE, 8'hA5, packet header byte.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  one-cycle strobe; capture in_data as one frame.
- in_data  in  N_CH*DATA_W  channel samples; channel 0 in the LSBs.
- stream_en  in  1  when high, packet transmission may start.
- flush  in  1  synchronous pulse; empties the buffer.
- out_data  out  8  current packet byte.
- out_valid  out  1  out_data is valid.
- out_ready  in  1  sink accepts out_data when out_valid is also high.
- frame_active  out  1  a packet is in progress.
- level  out  clog2(DEPTH)+1  frames currently stored.
- empty  out  1  level == 0.
- full  out  1  level == DEPTH.
- drop_count  out  16  saturating count of frames lost to overflow.

Behaviour:
- Reset: out_data=0, out_valid=0, frame_active=0, level=0, empty=1, full=0, drop_count=0, state=IDLE, both pointers=0.
- Storage: circular buffer of N_CH*DATA_W-bit entries. Pointers carry one extra wrap bit. Pointers wrap from DEPTH-1 to 0.
- Packet format: BPC = ceil(DATA_W/8).
  - Byte order: SYNC_BYTE; then for ch0..ch(N_CH-1), BPC bytes MSB-first; then CSUM.
  - Each sample is zero-extended to BPC*8 bits.
  - CSUM = XOR of all data bytes. SYNC_BYTE is excluded.
  - Packet length = N_CH*BPC + 2.
- Read FSM: IDLE -> SYNC -> DATA -> CSUM -> IDLE.
  - IDLE: if stream_en && !empty, latch the head entry into the shift register, pop (rd_ptr+1), clear the checksum and go to SYNC. out_valid is high in the following cycle.
  - SYNC, DATA, CSUM: out_valid=1. A byte advances only on a cycle where out_valid && out_ready.
  - DATA uses a byte counter from 0 to N_CH*BPC-1 and accumulates CSUM on each accepted byte.
  - On acceptance of CSUM, out_valid=0 and the FSM returns to IDLE. There is at least one idle cycle between packets.
  - out_data is stable while out_valid && !out_ready.
- Latency: with out_ready=1, the first byte (SYNC) is valid 2 clock edges after the in_valid edge. Packet bytes then follow one per cycle.
- Write side:
  - Write is accepted if !full, or if a pop occurs in the same cycle.
  - When full with no pop:
    - OVF_MODE=0: the frame is discarded and drop_count increments.
    - OVF_MODE=1: the frame is written at wr_ptr, rd_ptr advances, level stays at DEPTH, and drop_count increments.
  - Overwrite is safe mid-packet because the packet in flight is already latched.
- drop_count saturates at 16'hFFFF.
- level: +1 on an accepted write without a pop, -1 on a pop without a write, unchanged on both.
- stream_en low mid-packet: the current packet completes, and no new packet starts.
- flush: pointers and level are cleared next cycle. A packet in flight completes. drop_count is not cleared.
- flush together with in_valid: flush wins; the frame is discarded and not counted as a drop.
- Asserting reset mid-packet aborts immediately: out_valid drops asynchronously.

Decomposition:
- Package sample_frame_pkg:
  - FSM state enum (IDLE, SYNC, DATA, CSUM).
  - Constant function bytes_per_ch(DATA_W).
  - Default SYNC_BYTE constant.
- Sub-module frame_fifo_mem: simple dual-port storage array, written on accepted writes and read at rd_ptr. Pointers, level and overflow logic stay in the top.
- The serialiser FSM stays in the top module.

Test Plan:
- N_CH=2, DATA_W=22. Write ch0=0x3ABCDE, ch1=0x012345; stream_en=1; out_ready=1. Required bytes: A5 3A BC DE 01 23 45 3F. The first byte appears 2 edges after in_valid.
- Backpressure: same frame with out_ready toggling 1/0 each cycle. Required: identical 8 bytes, out_data held while not ready, no byte duplicated or lost.
- OVF_MODE=0, DEPTH=4, stream_en=0. Write frames 1..6. Required: level=4, full=1, drop_count=2. After enabling, packets for frames 1..4 in order.
- OVF_MODE=1, same stimulus. Required: drop_count=2, packets for frames 3..6 in order.
- Write 3 frames, start a packet, then pulse flush mid-packet. Required: the current packet completes with a correct CSUM, then level=0, empty=1, no further packets.
- Full buffer in OVF_MODE=0 with in_valid in the exact pop cycle. Required: the write is accepted, level stays 4, drop_count is unchanged.
